// File: rtl/mul_norm_round_pipe.sv
// mul_norm_round_pipe: two-stage normalize, round-to-nearest-even and pack stage of the FPU multiplier.
// Stage 1 registers the detector outputs; stage 2 shifts, rounds and packs into the output register.
module mul_norm_round_pipe #(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 10,
    parameter int BIAS   = 15
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [15:0]               i_data,
    input  logic [3:0]                i_pos_one,
    input  logic                      i_zero_flag,
    input  logic                      i_sign,
    input  logic signed [EXP_W+1:0]   i_exp,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [EXP_W+MANT_W:0]     o_result,
    output logic                      o_overflow,
    output logic                      o_underflow
);
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [15:0] S_MASK = 16'((1 << (14 - MANT_W)) - 1);

    if (MANT_W < 1 || MANT_W > 14 || BIAS <= 0) begin : g_bad_params
        $error("mul_norm_round_pipe: MANT_W must be 1..14 and BIAS positive");
    end

    logic                 v1, z1, s1;
    logic [15:0]          d1;
    logic [3:0]           lz1;
    logic signed [EW-1:0] e1;
    logic                 s1_load, s2_load;
    logic [15:0]          norm;
    logic signed [EW-1:0] exp_n, exp_r;
    logic [MANT_W-1:0]    frac, frac_r;
    logic                 g, st, up, carry, ovf, unf;
    logic [EXP_W+MANT_W:0] res;

    assign s2_load = ~o_valid | i_ready;
    assign s1_load = ~v1 | s2_load;
    assign o_ready = s1_load;

    always_comb begin
        norm   = d1 << lz1;
        exp_n  = e1 - EW'(lz1);
        frac   = norm[14 -: MANT_W];
        g      = norm[14 - MANT_W];
        st     = |(norm & S_MASK);
        up     = g & (st | frac[0]);
        carry  = up & (&frac);
        frac_r = frac + MANT_W'(up);
        exp_r  = exp_n + EW'(carry);
        ovf    = ~z1 & (exp_r >= EXP_MAX);
        unf    = ~z1 & ~ovf & (exp_r[EW-1] | ~|exp_r);
        res    = (z1 | unf) ? {s1, {(EXP_W+MANT_W){1'b0}}} :
                 ovf        ? {s1, {EXP_W{1'b1}}, {MANT_W{1'b0}}} :
                              {s1, exp_r[EXP_W-1:0], frac_r};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1  <= 1'b0;
            d1  <= '0;
            lz1 <= '0;
            z1  <= 1'b0;
            s1  <= 1'b0;
            e1  <= '0;
        end else if (s1_load) begin
            v1 <= i_valid;
            if (i_valid) begin
                d1  <= i_data;
                lz1 <= i_pos_one;
                z1  <= i_zero_flag;
                s1  <= i_sign;
                e1  <= i_exp;
            end
        end
    end

    // Payload only moves with a real beat; o_valid qualifies the held flags otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_result    <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (s2_load) begin
            o_valid <= v1;
            if (v1) begin
                o_result    <= res;
                o_overflow  <= ovf;
                o_underflow <= unf;
            end
        end
    end
endmodule

// File: tb/tb_mul_norm_round_pipe.sv
// tb_mul_norm_round_pipe: directed and randomized checks of the normalize/round pipeline
// against an integer-arithmetic reference model.
module tb_mul_norm_round_pipe;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_data = '0;
    logic [3:0]  i_pos_one = '0;
    logic        i_zero_flag = 1'b0;
    logic        i_sign = 1'b0;
    logic [6:0]  i_exp = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [15:0] o_result;
    logic        o_overflow;
    logic        o_underflow;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] r;
        bit          ov;
        bit          un;
    } exp_t;

    typedef struct {
        int d;
        bit z;
        bit s;
        int e;
        int r;
        bit ov;
        bit un;
    } vec_t;

    always #5 i_clk = ~i_clk;

    mul_norm_round_pipe dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_pos_one(i_pos_one), .i_zero_flag(i_zero_flag),
        .i_sign(i_sign), .i_exp(i_exp), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    function automatic int lzc_of(input logic [15:0] d);
        for (int i = 15; i >= 0; i--)
            if (d[i]) return 15 - i;
        return 0;
    endfunction

    // fp16 value from integer arithmetic: keep 11 significant bits, round half to even.
    function automatic exp_t model(input logic [15:0] d, input bit z, input bit s, input int e);
        exp_t o;
        int lz, norm, keep, rem, en;
        o.ov = 0;
        o.un = 0;
        o.r  = {s, 15'b0};
        if (z) return o;
        lz   = lzc_of(d);
        norm = (int'(d) << lz) & 32'hFFFF;
        keep = norm >> 5;
        rem  = norm & 31;
        en   = e - lz;
        if (rem > 16 || (rem == 16 && keep % 2 == 1)) keep++;
        if (keep == 2048) begin
            keep = 1024;
            en++;
        end
        if (en >= 31) begin
            o.ov = 1;
            o.r  = {s, 5'h1F, 10'b0};
        end else if (en <= 0) begin
            o.un = 1;
        end else begin
            o.r = {s, en[4:0], keep[9:0]};
        end
        return o;
    endfunction

    task automatic drive(input logic [15:0] d, input bit z, input bit s, input int e, input bit v);
        i_valid     = v;
        i_data      = d;
        i_zero_flag = z;
        i_sign      = s;
        i_exp       = e[6:0];
        i_pos_one   = z ? 4'($urandom) : 4'(lzc_of(d));
    endtask

    task automatic send_one(input logic [15:0] d, input bit z, input bit s, input int e,
                            output logic [15:0] r, output bit ov, output bit un, output int lat);
        drive(d, z, s, e, 1'b1);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            @(posedge i_clk); #1;
            lat++;
        end
        r  = o_result;
        ov = o_overflow;
        un = o_underflow;
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        #3;
        checks++;
        if ({o_valid, o_overflow, o_underflow, o_result} !== 19'd0) begin
            failures++;
            $display("FAIL reset_state: got v=%b ov=%b un=%b r=%h, want all zero", o_valid, o_overflow, o_underflow, o_result);
        end
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got o_ready=%b, want 1", o_ready);
        end
    endtask

    task automatic test_basic();
        logic [15:0] r;
        bit ov, un;
        int lat;
        send_one(16'h8000, 1'b0, 1'b0, 15, r, ov, un, lat);
        checks++;
        if (r !== 16'h3C00 || ov || un) begin
            failures++;
            $display("FAIL basic_value: got r=%h ov=%b un=%b, want 3c00 0 0", r, ov, un);
        end
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles, want 2", lat);
        end
    endtask

    task automatic test_directed();
        vec_t vecs[11] = '{
            '{32'h0010, 0, 0, 20, 32'h2400, 0, 0},
            '{32'h0010, 0, 1, 20, 32'hA400, 0, 0},
            '{32'h8030, 0, 0, 15, 32'h3C02, 0, 0},
            '{32'h8010, 0, 0, 15, 32'h3C00, 0, 0},
            '{32'hFFF0, 0, 0, 15, 32'h4000, 0, 0},
            '{32'h8000, 0, 0, 31, 32'h7C00, 1, 0},
            '{32'h0800, 0, 0, 3,  32'h0000, 0, 1},
            '{32'h0000, 1, 1, 31, 32'h8000, 0, 0},
            '{32'hFFF0, 0, 1, 30, 32'hFC00, 1, 0},
            '{32'h8000, 0, 0, 1,  32'h0400, 0, 0},
            '{32'h4000, 0, 0, 1,  32'h0000, 0, 1}
        };
        logic [15:0] r;
        bit ov, un;
        int lat;
        foreach (vecs[k]) begin
            send_one(16'(vecs[k].d), vecs[k].z, vecs[k].s, vecs[k].e, r, ov, un, lat);
            checks++;
            if (r !== 16'(vecs[k].r) || ov !== vecs[k].ov || un !== vecs[k].un || lat != 2) begin
                failures++;
                $display("FAIL directed_%0d: got r=%h ov=%b un=%b lat=%0d, want r=%h ov=%b un=%b lat=2",
                         k, r, ov, un, lat, 16'(vecs[k].r), vecs[k].ov, vecs[k].un);
            end
        end
    endtask

    // rnd=0: back-to-back beats with i_ready low for cycles 3..5; rnd=1: random valid/ready.
    task automatic run_stream(input int n, input bit rnd);
        exp_t sb[$];
        exp_t want;
        logic [15:0] d = '0;
        logic [17:0] held = '0;
        bit z = 0, s = 0, have = 0, in_f, out_f, hold = 0, saw_drop = 0;
        int e = 0, sent = 0, got = 0, cyc = 0;
        while (got < n && cyc < 3000) begin
            if (sent < n && !have) begin
                d = 16'($urandom) >> $urandom_range(15);
                if ($urandom_range(15) == 0) d = '0;
                z = (d == 0);
                s = 1'($urandom);
                e = int'($urandom_range(70)) - 20;
                have = 1;
            end
            drive(d, z, s, e, have && (rnd ? ($urandom_range(3) != 0) : 1'b1));
            i_ready = rnd ? ($urandom_range(2) != 0) : !(cyc >= 3 && cyc < 6);
            @(negedge i_clk);
            if (hold) begin
                checks++;
                if ({o_valid, o_overflow, o_underflow, o_result} !== {1'b1, held}) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b flags/result=%h, want v=1 %h", o_valid, {o_overflow, o_underflow, o_result}, held);
                end
            end
            in_f = i_valid & o_ready;
            out_f = o_valid & i_ready;
            if (i_valid && !o_ready) saw_drop = 1;
            if (out_f) begin
                checks++;
                got++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra: got unexpected result %h, want none", o_result);
                end else begin
                    want = sb.pop_front();
                    if ({o_overflow, o_underflow, o_result} !== {want.ov, want.un, want.r}) begin
                        failures++;
                        $display("FAIL stream_result: got r=%h ov=%b un=%b, want r=%h ov=%b un=%b",
                                 o_result, o_overflow, o_underflow, want.r, want.ov, want.un);
                    end
                end
            end
            hold = o_valid & ~i_ready;
            held = {o_overflow, o_underflow, o_result};
            if (in_f) begin
                sb.push_back(model(d, z, s, e));
                sent++;
                have = 0;
            end
            @(posedge i_clk); #1;
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        checks++;
        if (got != n || sent != n || sb.size() != 0) begin
            failures++;
            $display("FAIL stream_count: got sent=%0d received=%0d pending=%0d, want %0d %0d 0", sent, got, sb.size(), n, n);
        end
        if (!rnd) begin
            checks++;
            if (!saw_drop) begin
                failures++;
                $display("FAIL ready_drop: got o_ready never low while stalled, want a drop");
            end
        end
    endtask

    task automatic test_back_to_back();
        run_stream(6, 1'b0);
    endtask

    task automatic test_random();
        run_stream(300, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        bit ov, un;
        int lat;
        i_ready = 1'b1;
        drive(16'h8000, 1'b0, 1'b0, 31, 1'b1);
        @(posedge i_clk); #1;
        drive(16'h8000, 1'b0, 1'b1, 31, 1'b1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_overflow !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: got v=%b ov=%b, want 1 1", o_valid, o_overflow);
        end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if ({o_valid, o_overflow, o_underflow, o_result} !== 19'd0) begin
            failures++;
            $display("FAIL async_reset: got v=%b ov=%b un=%b r=%h, want all zero", o_valid, o_overflow, o_underflow, o_result);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        send_one(16'h8000, 1'b0, 1'b0, 15, r, ov, un, lat);
        checks++;
        if (r !== 16'h3C00 || ov || un || lat != 2) begin
            failures++;
            $display("FAIL post_reset: got r=%h ov=%b un=%b lat=%0d, want 3c00 0 0 2", r, ov, un, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
